// File: rtl/led_pkg.sv
// Shared mode encodings and PWM width for the LED pattern engine.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_SCAN = 2'd2;
  localparam logic [1:0] MODE_GRAY = 2'd3;

  localparam int PWM_W = 4;

endpackage

// File: rtl/led_prescaler.sv
// Programmable prescaler: one advance strobe every 2^(BASE_SHIFT+rate_sel) cycles.
module led_prescaler #(
  parameter int PRESCALE_W = 32,
  parameter int BASE_SHIFT = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rate_sel,
  input  logic       pause,
  output logic       adv_auto
);

  localparam logic [PRESCALE_W-1:0] ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRESCALE_W-1:0] limit;
  logic [7:0]            shamt;
  logic                  at_limit;

  // >= rather than == so a rate drop mid-count fires on the next cycle.
  always_comb begin
    shamt    = 8'(BASE_SHIFT) + {4'd0, rate_sel};
    limit    = (ONE << shamt) - ONE;
    at_limit = (pre_cnt_q >= limit);
    adv_auto = ~pause & at_limit;
    if (pause || at_limit) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: UP/DOWN/SCAN/GRAY stepping with pause and single-step.
// Optional duty-cycle dimming of the LED bank when LED_PWM_EN is defined.
module led_pattern_gen import led_pkg::*; #(
  parameter int LED_W      = 16,
  parameter int PRESCALE_W = 32,
  parameter int BASE_SHIFT = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [3:0]       rate_sel,
  input  logic             pause,
  input  logic             step,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] duty,
`endif
  output logic [LED_W-1:0] led,
  output logic             tick
);

  localparam logic [LED_W-1:0] ONE = {{(LED_W-1){1'b0}}, 1'b1};

  logic [LED_W-1:0] value_q, value_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [LED_W-1:0] pattern;
  logic [1:0]       mode_q;
  logic             dir_q, dir_d;
  logic             step_q;
  logic             tick_q;
  logic             adv_auto, adv, step_edge, reload, is_onehot;

  led_prescaler #(
    .PRESCALE_W (PRESCALE_W),
    .BASE_SHIFT (BASE_SHIFT)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .rate_sel (rate_sel),
    .pause    (pause),
    .adv_auto (adv_auto)
  );

  always_comb begin
    step_edge = step & ~step_q;
    adv       = pause ? step_edge : adv_auto;
    reload    = (mode != mode_q);
    is_onehot = (value_q != '0) && ((value_q & (value_q - ONE)) == '0);

    value_d = value_q;
    dir_d   = dir_q;
    if (reload) begin
      dir_d = 1'b0;
      case (mode)
        MODE_DOWN: value_d = '1;
        MODE_SCAN: value_d = ONE;
        default:   value_d = '0;
      endcase
    end else if (mode_q == MODE_SCAN && !is_onehot) begin
      value_d = ONE;
      dir_d   = 1'b0;
    end else if (adv) begin
      case (mode_q)
        MODE_DOWN: value_d = value_q - ONE;
        MODE_SCAN: begin
          // Direction flips on arrival at an end bit so the next step turns back.
          if (!dir_q) begin
            value_d = value_q << 1;
            dir_d   = value_d[LED_W-1];
          end else begin
            value_d = value_q >> 1;
            dir_d   = ~value_d[0];
          end
        end
        default:   value_d = value_q + ONE;
      endcase
    end

    pattern = (mode_q == MODE_GRAY) ? (value_q ^ (value_q >> 1)) : value_q;
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q;
  logic             pwm_on;

  always_comb begin
    pwm_on = (duty == 4'hF) || (pwm_cnt_q < duty);
    led_d  = pattern & {LED_W{pwm_on}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
    end
  end
`else
  always_comb begin
    led_d = pattern;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      dir_q   <= 1'b0;
      mode_q  <= MODE_UP;
      step_q  <= 1'b0;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      dir_q   <= dir_d;
      mode_q  <= mode;
      step_q  <= step;
      led_q   <= led_d;
      tick_q  <= adv;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule
